// File: rtl/fpu_addsub_seq.sv
// fpu_addsub_seq: issues one FP16 add/sub at a time to an external Add_Sub unit,
// waits LATENCY cycles, then holds the tagged result until the consumer takes it.
module fpu_addsub_seq #(
  parameter int LATENCY = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_op_i,
  input  logic [15:0]      in_a_i,
  input  logic [15:0]      in_b_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             add_op_o,
  output logic [15:0]      add_a_o,
  output logic [15:0]      add_b_o,
  input  logic [15:0]      add_c_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [15:0]      out_c_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             busy_o,
  output logic [15:0]      ops_cnt_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic op_q, op_d;
  logic [15:0] a_q, a_d, b_q, b_d, c_q, c_d, ops_cnt_q, ops_cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic accept, resp_hs, done;
  always_comb begin
    resp_hs = state_q == RESP && out_ready_i;
    in_ready_o = !rst_i && (state_q == IDLE || resp_hs);
    accept = in_valid_i && in_ready_o;
    done = state_q == EXEC && cnt_q == 3'd0;
    state_d = accept ? EXEC : resp_hs ? IDLE : done ? RESP : state_q;
    cnt_d = accept ? CNT_INIT : (state_q == EXEC && !done) ? cnt_q - 3'd1 : cnt_q;
    op_d = accept ? in_op_i : op_q;
    a_d = accept ? in_a_i : a_q;
    b_d = accept ? in_b_i : b_q;
    tag_d = accept ? in_tag_i : tag_q;
    c_d = done ? add_c_i : c_q;
    ops_cnt_d = ops_cnt_q + 16'(resp_hs);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      tag_q <= '0;
      c_q <= '0;
      ops_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      tag_q <= tag_d;
      c_q <= c_d;
      ops_cnt_q <= ops_cnt_d;
    end
  end
  assign add_op_o = op_q;
  assign add_a_o = a_q;
  assign add_b_o = b_q;
  assign out_valid_o = state_q == RESP;
  assign out_c_o = c_q;
  assign out_tag_o = tag_q;
  assign busy_o = state_q != IDLE;
  assign ops_cnt_o = ops_cnt_q;
endmodule

// File: tb/tb_fpu_addsub_seq.sv
// tb_fpu_addsub_seq: two lanes (LATENCY 1 and 4) driven by random and directed requests;
// a queue of outstanding requests predicts valid/busy/ready/result every cycle.
module tb_fpu_addsub_seq;
  typedef struct {
    logic op;
    logic [15:0] a, b, c;
    logic [3:0] tag;
    int acc;
  } exp_t;
  logic clk = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic done [2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // reference adder result: plain integer add/sub, wrapped to 16 bits
  function automatic logic [15:0] ref_c(logic op, logic [15:0] a, logic [15:0] b);
    int r;
    r = op ? int'(a) - int'(b) : int'(a) + int'(b);
    return r[15:0];
  endfunction
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = g == 0 ? 1 : 4;
    logic rst = 1, in_valid = 0, in_op = 0, out_ready = 0, rand_rdy = 0;
    logic [15:0] in_a = 0, in_b = 0, noise = 0, exp_cnt = 0;
    logic [3:0] in_tag = 0;
    logic in_ready, add_op, out_valid, busy;
    logic [15:0] add_a, add_b, add_c, out_c, ops_cnt;
    logic [3:0] out_tag;
    exp_t q[$];
    assign add_c = (add_op ? add_a - add_b : add_a + add_b) ^ noise;
    fpu_addsub_seq #(.LATENCY(LAT), .TAG_W(4)) u_dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_op_i(in_op), .in_a_i(in_a), .in_b_i(in_b), .in_tag_i(in_tag),
      .add_op_o(add_op), .add_a_o(add_a), .add_b_o(add_b), .add_c_i(add_c),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_c_o(out_c),
      .out_tag_o(out_tag), .busy_o(busy), .ops_cnt_o(ops_cnt)
    );
    function automatic string nm(string s);
      return $sformatf("lat%0d_%s", LAT, s);
    endfunction
    task automatic send(logic op, logic [15:0] a, logic [15:0] b, logic [3:0] tag);
      logic ok;
      ok = 0;
      in_valid = 1;
      in_op = op;
      in_a = a;
      in_b = b;
      in_tag = tag;
      for (int i = 0; i < 40 && !ok; i++) begin
        #1;
        if (in_ready) begin
          q.push_back('{op, a, b, ref_c(op, a, b), tag, cyc + 1});
          ok = 1;
        end
        @(negedge clk);
      end
      if (!ok) chk(nm("accept_timeout"), 0, 1);
    endtask
    task automatic idle(int n);
      in_valid = 0;
      repeat (n) @(negedge clk);
    endtask
    task automatic drain;
      in_valid = 0;
      for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk);
      chk(nm("drain"), q.size(), 0);
    endtask
    task automatic do_reset;
      rst = 1;
      in_valid = 1;
      in_a = 16'hAAAA;
      noise = 0;
      q.delete();
      #1 chk(nm("ready_in_rst"), in_ready, 0);
      @(negedge clk);
      rst = 0;
      in_valid = 0;
      #1;
      chk(nm("rst_valid"), out_valid, 0);
      chk(nm("rst_c"), out_c, 0);
      chk(nm("rst_tag"), out_tag, 0);
      chk(nm("rst_add"), {add_op, add_a, add_b}, 0);
      chk(nm("rst_cnt"), ops_cnt, 0);
      chk(nm("rst_busy"), busy, 0);
      chk(nm("rst_ready"), in_ready, 1);
      @(negedge clk);
    endtask
    initial begin
      logic ev, eb;
      forever begin
        @(negedge clk);
        #2;
        if (rst) exp_cnt = 0;
        else begin
          ev = q.size() > 0 && q[0].acc + LAT <= cyc;
          eb = q.size() > 0 && q[0].acc <= cyc;
          chk(nm("valid"), out_valid, ev);
          chk(nm("busy"), busy, eb);
          chk(nm("in_ready"), in_ready, ev ? out_ready : !eb);
          chk(nm("ops_cnt"), ops_cnt, exp_cnt);
          if (eb) chk(nm("add_ops"), {add_op, add_a, add_b}, {q[0].op, q[0].a, q[0].b});
          if (ev) begin
            chk(nm("out_c"), out_c, q[0].c);
            chk(nm("out_tag"), out_tag, q[0].tag);
            if (out_ready) begin
              void'(q.pop_front());
              exp_cnt++;
            end
          end
        end
      end
    end
    initial forever begin
      @(negedge clk);
      if (rand_rdy) out_ready = 1'($urandom);
    end
    initial begin
      done[g] = 0;
      @(negedge clk);
      do_reset();
      out_ready = 1;
      send(0, 16'h3C00, 16'h4000, 4'd3);
      drain();
      chk(nm("first_cnt"), ops_cnt, 1);
      out_ready = 0;
      send(1, 16'($urandom), 16'($urandom), 4'd5);
      idle(LAT);
      repeat (5) begin
        noise = 16'($urandom) | 16'h1;
        @(negedge clk);
      end
      noise = 0;
      out_ready = 1;
      drain();
      for (int i = 0; i < 20; i++) send(1'($urandom), 16'($urandom), 16'($urandom), 4'(i));
      drain();
      chk(nm("b2b_cnt"), ops_cnt, 22);
      send(0, 16'h1234, 16'h0F0F, 4'd9);
      do_reset();
      send(1, 16'h5000, 16'h0123, 4'd7);
      drain();
      chk(nm("post_rst_cnt"), ops_cnt, 1);
      rand_rdy = 1;
      for (int i = 0; i < 30; i++) begin
        send(1'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
        idle($urandom_range(0, 2));
      end
      rand_rdy = 0;
      out_ready = 1;
      drain();
      @(posedge clk);
      #1;
      force u_dut.ops_cnt_q = 16'hFFFF;
      exp_cnt = 16'hFFFF;
      @(posedge clk);
      #1;
      release u_dut.ops_cnt_q;
      @(negedge clk);
      chk(nm("preload"), ops_cnt, 16'hFFFF);
      send(0, 16'h0001, 16'h0002, 4'd1);
      drain();
      chk(nm("wrap"), ops_cnt, 0);
      done[g] = 1;
    end
  end
  initial begin
    for (int i = 0; i < 20000 && !(done[0] === 1'b1 && done[1] === 1'b1); i++) @(posedge clk);
    if (!(done[0] === 1'b1 && done[1] === 1'b1)) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: lanes done %b%b required 11", done[1], done[0]);
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_addsub_seq.md
FPU_ADDSUB_SEQ -- requirements
Module: fpu_addsub_seq

Interface
REQ-001 Parameter LATENCY, default 1, meaning cycles from operand issue to result capture from the adder; legal range 1..8.
REQ-002 Parameter TAG_W, default 4, meaning width of the request tag passed through to the response.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset, sampled on rising edge of clk_i.
REQ-005 in_valid_i  input  1  request valid.
REQ-006 in_ready_o  output  1  request accepted when in_valid_i & in_ready_o at a rising edge.
REQ-007 in_op_i  input  1  operation select, forwarded unchanged to the adder's operator_i encoding.
REQ-008 in_a_i  input  16  operand A, 16-bit FP.
REQ-009 in_b_i  input  16  operand B, 16-bit FP.
REQ-010 in_tag_i  input  TAG_W  request tag.
REQ-011 add_op_o  output  1  drives Add_Sub operator_i.
REQ-012 add_a_o  output  16  drives Add_Sub A.
REQ-013 add_b_o  output  16  drives Add_Sub B.
REQ-014 add_c_i  input  16  Add_Sub result C.
REQ-015 out_valid_o  output  1  response valid.
REQ-016 out_ready_i  input  1  response consumed when out_valid_o & out_ready_i at a rising edge.
REQ-017 out_c_o  output  16  captured result.
REQ-018 out_tag_o  output  TAG_W  tag of the accepted request.
REQ-019 busy_o  output  1  high in any state other than IDLE.
REQ-020 ops_cnt_o  output  16  count of completed responses.

Function
REQ-021 FSM states SHALL be IDLE, EXEC, RESP.
REQ-022 On acceptance, op/A/B/tag SHALL be registered; add_op_o/add_a_o/add_b_o SHALL come from these registers only and stay stable until the next acceptance.
REQ-023 IDLE: in_ready_o=1; on acceptance go EXEC with a down-counter loaded to LATENCY-1.
REQ-024 EXEC: in_ready_o=0; counter decrements each cycle; at the edge where counter==0, add_c_i SHALL be captured into out_c_o and the state SHALL go to RESP.
REQ-025 Latency: out_valid_o SHALL rise exactly LATENCY cycles after the acceptance edge (LATENCY=1: high after the following edge).
REQ-026 RESP: out_valid_o=1; out_c_o and out_tag_o SHALL hold stable while out_ready_i=0 (no drop, no change).
REQ-027 RESP: in_ready_o SHALL equal out_ready_i (combinational).
REQ-028 RESP with response handshake and no new request: go IDLE, out_valid_o=0 next cycle.
REQ-029 RESP with response handshake and simultaneous request acceptance: go EXEC with the new operands latched; no idle bubble.
REQ-030 ops_cnt_o SHALL increment by 1 on each response handshake and wrap from 16'hFFFF to 16'h0000.
REQ-031 out_valid_o SHALL never be high in IDLE or EXEC; in_valid_i in EXEC SHALL be ignored (no acceptance).
REQ-032 busy_o SHALL be high in EXEC and RESP.

Reset
REQ-033 While rst_i is high at an edge: state IDLE, counter 0, out_valid_o=0, out_c_o=0, out_tag_o=0, add_op_o=0, add_a_o=0, add_b_o=0, ops_cnt_o=0, busy_o=0.
REQ-034 in_ready_o SHALL be 0 while rst_i is high and 1 in the first cycle after rst_i deasserts.
REQ-035 Reset during EXEC or RESP SHALL discard the transaction; no out_valid_o pulse for it afterwards; a request presented during reset SHALL NOT be accepted.

Verification
REQ-036 LATENCY=1, op=0, A=16'h3C00, B=16'h4000, tag=3, out_ready_i=1 -> out_valid_o exactly 1 cycle after acceptance, out_c_o equals Add_Sub C for those inputs, out_tag_o=3, ops_cnt_o=1.
REQ-037 LATENCY=4, single request -> out_valid_o rises exactly 4 cycles after acceptance; busy_o high through those 4 cycles and the response cycle.
REQ-038 out_ready_i held 0 for 5 cycles in RESP while add_c_i inputs change -> out_c_o/out_tag_o unchanged, in_ready_o=0, then one handshake, ops_cnt_o +1.
REQ-039 20 back-to-back random requests (in_valid_i=1, out_ready_i=1) with tags 0..19 mod 2^TAG_W -> every result matches Add_Sub C in order, no bubble between RESP and next EXEC, ops_cnt_o=20.
REQ-040 rst_i asserted one cycle in EXEC -> no out_valid_o for that request, all outputs zero, in_ready_o=1 next cycle; next request completes normally.
REQ-041 ops_cnt_o preloaded to 16'hFFFF via 65535 completions (or force) -> next handshake gives 16'h0000.
